// File: rtl/align_pack_ctrl.sv
// align_pack_ctrl: sequences group-config changes for the compaction stage and packs compacted samples into 32-bit words
module align_pack_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cfg_groups,
  input  logic        cfg_load,
  output logic        cfg_busy,
  output logic [3:0]  ctl_disabledGroups,
  input  logic        flush,
  input  logic        sti_valid,
  input  logic [31:0] sti_data,
  output logic        sto_valid,
  input  logic        sto_ready,
  output logic [31:0] sto_data,
  output logic [3:0]  sto_keep,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE, DRAIN, SETTLE} state_t;
  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d, acc_s;
  logic [3:0]  cnt_q, cnt_d, dis_q, dis_d, pend_q, pend_d, popped, base;
  logic [2:0]  w_q, w_d;
  logic [7:0]  sc_q, sc_d;
  logic        cfg_pend_q, cfg_pend_d, ovf_q, ovf_d, pop, space, accept, drop;
  logic [31:0] wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      dis_q      <= '0;
      pend_q     <= '0;
      w_q        <= 3'd4;
      sc_q       <= '0;
      cfg_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dis_q      <= dis_d;
      pend_q     <= pend_d;
      w_q        <= w_d;
      sc_q       <= sc_d;
      cfg_pend_q <= cfg_pend_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cfg_pend_d = cfg_pend_q;
    dis_d      = dis_q;
    w_d        = w_q;
    sc_d       = sc_q;
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          state_d    = DRAIN;
          pend_d     = cfg_groups;
          cfg_pend_d = 1'b1;
        end else if (flush) begin
          state_d    = DRAIN;
          cfg_pend_d = 1'b0;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = cfg_pend_q ? SETTLE : IDLE;
          dis_d   = cfg_pend_q ? pend_q : dis_q;
          sc_d    = '0;
        end
      end
      SETTLE: begin
        // the new mask takes effect on W only once the compaction pipeline has flushed its old output
        if (sc_q == 8'(SETTLE_CYCLES - 1)) begin
          state_d    = IDLE;
          w_d        = 3'(3'd4 - 3'($countones(dis_q)));
          cfg_pend_d = 1'b0;
        end else begin
          sc_d = sc_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sto_valid          = (cnt_q >= 4'd4) | (state_q == DRAIN && cnt_q != 4'd0);
    sto_data           = acc_q[31:0];
    sto_keep           = (cnt_q >= 4'd4) ? 4'hF : ~(4'hF << cnt_q);
    cfg_busy           = state_q != IDLE;
    ctl_disabledGroups = dis_q;
    ovf                = ovf_q;
    pop                = sto_valid & sto_ready;
    popped             = pop ? ((cnt_q >= 4'd4) ? 4'd4 : cnt_q) : 4'd0;
    base               = cnt_q - popped;
    acc_s              = pop ? {32'b0, acc_q[63:32]} : acc_q;
    space              = 5'(base) + 5'(w_q) <= 5'd8;
    accept             = state_q == IDLE && sti_valid && w_q != 3'd0 && space;
    drop               = state_q == IDLE && sti_valid && w_q != 3'd0 && !space;
    wmask              = ~(32'hFFFF_FFFF << {w_q, 3'b0});
    acc_d              = accept ? acc_s | ({32'b0, sti_data & wmask} << {base, 3'b0}) : acc_s;
    cnt_d              = base + (accept ? {1'b0, w_q} : 4'd0);
    ovf_d              = (state_q == IDLE && cfg_load) ? 1'b0 : ovf_q | drop;
  end
endmodule

// File: tb/tb_align_pack_ctrl.sv
// tb_align_pack_ctrl: directed stimulus with a queue scoreboard checked by an output monitor
module tb_align_pack_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  cfg_groups = '0;
  logic        cfg_load = 1'b0, flush = 1'b0, sti_valid = 1'b0, sto_ready = 1'b0;
  logic [31:0] sti_data = '0;
  logic        cfg_busy, sto_valid, ovf;
  logic [3:0]  ctl_disabledGroups, sto_keep;
  logic [31:0] sto_data;
  typedef struct {logic [31:0] d; logic [3:0] k;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  align_pack_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cfg_groups(cfg_groups), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
    .ctl_disabledGroups(ctl_disabledGroups), .flush(flush), .sti_valid(sti_valid), .sti_data(sti_data),
    .sto_valid(sto_valid), .sto_ready(sto_ready), .sto_data(sto_data), .sto_keep(sto_keep), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    sti_valid = 1'b1;
    sti_data  = d;
    step();
    sti_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    exp_t e;
    e.d = d;
    e.k = k;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && sto_valid && sto_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h keep %h expected none", sto_data, sto_keep);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_data", sto_data & bmask(e.k), e.d);
        chk("word_keep", {28'b0, sto_keep}, {28'b0, e.k});
      end
    end
  end

  initial begin
    #12;
    chk("rst_valid", {31'b0, sto_valid}, 0);
    chk("rst_keep", {28'b0, sto_keep}, 0);
    chk("rst_data", sto_data, 0);
    chk("rst_busy", {31'b0, cfg_busy}, 0);
    chk("rst_ctl", {28'b0, ctl_disabledGroups}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    step();
    rst = 1'b0;
    step();
    // pass-through at W=4
    sto_ready = 1'b1;
    expect_word(32'h11223344, 4'hF);
    expect_word(32'h55667788, 4'hF);
    sti_valid = 1'b1;
    sti_data  = 32'h11223344;
    step();
    sti_data = 32'h55667788;
    chk("pt_valid_a", {31'b0, sto_valid}, 1);
    step();
    sti_valid = 1'b0;
    chk("pt_valid_b", {31'b0, sto_valid}, 1);
    step();
    chk("pt_idle", {31'b0, sto_valid}, 0);
    // configure W=1; samples during busy must be discarded
    cfg_groups = 4'b0111;
    cfg_load   = 1'b1;
    step();
    cfg_load  = 1'b0;
    sti_valid = 1'b1;
    sti_data  = 32'hEEEEEEEE;
    chk("cfg_busy_drain", {31'b0, cfg_busy}, 1);
    step();
    chk("cfg_busy_s1", {31'b0, cfg_busy}, 1);
    chk("cfg_ctl", {28'b0, ctl_disabledGroups}, 32'h7);
    step();
    chk("cfg_busy_s2", {31'b0, cfg_busy}, 1);
    step();
    chk("cfg_busy_done", {31'b0, cfg_busy}, 0);
    expect_word(32'hDDCCBBAA, 4'hF);
    send(32'h000000AA);
    send(32'h000000BB);
    send(32'h000000CC);
    send(32'h000000DD);
    step();
    step();
    // flush of a partial word at W=1
    send(32'h000000AA);
    send(32'h000000BB);
    expect_word(32'h0000BBAA, 4'b0011);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    step();
    chk("flush_idle", {31'b0, cfg_busy}, 0);
    chk("flush_ctl", {28'b0, ctl_disabledGroups}, 32'h7);
    // W=3 packing across word boundaries
    cfg_groups = 4'b1000;
    cfg_load   = 1'b1;
    step();
    cfg_load = 1'b0;
    for (int i = 0; i < 10 && cfg_busy; i++) step();
    chk("w3_ready", {31'b0, cfg_busy}, 0);
    chk("w3_ctl", {28'b0, ctl_disabledGroups}, 32'h8);
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    expect_word(32'h0C0B0A09, 4'hF);
    send(32'h00030201);
    send(32'h00060504);
    send(32'h00090807);
    send(32'h000C0B0A);
    step();
    step();
    chk("w3_empty_keep", {28'b0, sto_keep}, 0);
    chk("w3_empty_valid", {31'b0, sto_valid}, 0);
    // asynchronous reset with three bytes buffered
    sto_ready = 1'b0;
    send(32'h00030201);
    chk("mid_keep", {28'b0, sto_keep}, 32'h7);
    chk("mid_valid", {31'b0, sto_valid}, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, sto_valid}, 0);
    chk("arst_keep", {28'b0, sto_keep}, 0);
    chk("arst_ctl", {28'b0, ctl_disabledGroups}, 0);
    chk("arst_busy", {31'b0, cfg_busy}, 0);
    chk("arst_ovf", {31'b0, ovf}, 0);
    step();
    rst = 1'b0;
    step();
    // overflow at W=4 with a stalled output
    send(32'hA0A1A2A3);
    send(32'hB0B1B2B3);
    send(32'hC0C1C2C3);
    chk("ovf_set", {31'b0, ovf}, 1);
    chk("ovf_keep", {28'b0, sto_keep}, 32'hF);
    chk("ovf_head", sto_data, 32'hA0A1A2A3);
    step();
    chk("ovf_sticky", {31'b0, ovf}, 1);
    expect_word(32'hA0A1A2A3, 4'hF);
    expect_word(32'hB0B1B2B3, 4'hF);
    sto_ready = 1'b1;
    step();
    step();
    chk("ovf_drained", {31'b0, sto_valid}, 0);
    chk("ovf_still", {31'b0, ovf}, 1);
    cfg_groups = 4'b0000;
    cfg_load   = 1'b1;
    step();
    cfg_load = 1'b0;
    chk("ovf_clear", {31'b0, ovf}, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d words pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
